exe_wb_arbiter: RTL and testbench

Parametrised result-collection and writeback arbiter for the execution stage. It accepts completed results from NUM_FU functional units (ALU, branch, mul, div, mem, ...) that finish in arbitrary cycles. Each unit has its own small result FIFO, and one result per cycle is granted to the single writeback port. It replaces the fixed functional-unit result mux with buffered, back-pressured, killable completion.

---
 rtl/drac_pkg.sv | 12 +
 rtl/exe_wb_arbiter_result_fifo.sv | 41 ++++
 rtl/exe_wb_arbiter.sv | 73 +++++++
 tb/tb_exe_wb_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// drac_pkg: shared defaults and the writeback result record for the execution stage.
package drac_pkg;
    localparam int DEF_NUM_FU = 4;
    localparam int DEF_DEPTH  = 2;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RD_W   = 5;
    typedef struct packed {
        logic [DEF_RD_W-1:0]           rd;
        logic [DEF_DATA_W-1:0]         data;
        logic [$clog2(DEF_NUM_FU)-1:0] fu;
    } exe_wb_result_t;
endpackage

// File: rtl/exe_wb_arbiter_result_fifo.sv
// result_fifo: per-unit result buffer; caller gates push with ~full and pop with ~empty.
module result_fifo
    import drac_pkg::*;
#(
    parameter int W     = DEF_DATA_W + DEF_RD_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rdata_o = mem_q[rp_q];
    assign cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + PW'(1);
            if (pop_i) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i && !flush_i) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter: buffers functional-unit results per channel and grants one per cycle
// to the writeback port, round-robin or fixed priority, with flush on kill.
module exe_wb_arbiter
    import drac_pkg::*;
#(
    parameter int NUM_FU  = DEF_NUM_FU,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int RR_MODE = 1,
    parameter int DROP_X0 = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       kill_i,
    input  logic [NUM_FU-1:0]          fu_valid_i,
    input  logic [NUM_FU*RD_W-1:0]     fu_rd_i,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data_i,
    output logic [NUM_FU-1:0]          fu_ready_o,
    output logic                       wb_valid_o,
    output logic [RD_W-1:0]            wb_rd_o,
    output logic [DATA_W-1:0]          wb_data_o,
    output logic [$clog2(NUM_FU)-1:0]  wb_fu_o,
    input  logic                       wb_ready_i,
    output logic                       stall_o
);
    localparam int FW = $clog2(NUM_FU);
    localparam logic [FW:0] NF = (FW + 1)'(NUM_FU);
    logic [NUM_FU-1:0]      push, pop, full, ne;
    logic [RD_W+DATA_W-1:0] head [NUM_FU];
    logic [FW-1:0]          rr_q, rr_d, base, off, grant;
    logic [NUM_FU-1:0]      rot;
    logic [FW:0]            sum;
    logic                   pop_en;
    for (genvar k = 0; k < NUM_FU; k++) begin : g_ch
        logic empty;
        assign push[k] = fu_valid_i[k] & ~full[k] & ~kill_i
                       & ~(DROP_X0 != 0 && fu_rd_i[k*RD_W +: RD_W] == '0);
        assign pop[k]  = pop_en & (grant == FW'(k));
        assign ne[k]   = ~empty;
        result_fifo #(.W(RD_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (kill_i),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .wdata_i ({fu_rd_i[k*RD_W +: RD_W], fu_data_i[k*DATA_W +: DATA_W]}),
            .rdata_o (head[k]),
            .full_o  (full[k]),
            .empty_o (empty)
        );
    end
    // rotate so the search starts at base, pick lowest set bit, rotate the index back
    always_comb begin
        base = RR_MODE != 0 ? rr_q : '0;
        rot  = NUM_FU'({ne, ne} >> base);
        off  = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) off = rot[i] ? FW'(i) : off;
        sum   = {1'b0, base} + {1'b0, off};
        grant = sum >= NF ? FW'(sum - NF) : FW'(sum);
        rr_d  = grant == FW'(NUM_FU - 1) ? '0 : grant + FW'(1);
    end
    assign fu_ready_o           = ~full;
    assign stall_o              = |full;
    assign wb_valid_o           = |ne & ~kill_i;
    assign pop_en               = wb_valid_o & wb_ready_i;
    assign {wb_rd_o, wb_data_o} = wb_valid_o ? head[grant] : '0;
    assign wb_fu_o              = wb_valid_o ? grant : '0;
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= '0;
        else if (pop_en && RR_MODE != 0) rr_q <= rr_d;
    end
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb_exe_wb_arbiter: drives a round-robin/drop-x0 instance and a fixed-priority/keep-x0
// instance with identical stimulus and compares both against queue-based models.
module tb_exe_wb_arbiter;
    import drac_pkg::*;
    logic clk = 0;
    logic rst, kill, wb_ready;
    logic [3:0] fu_valid;
    logic [19:0] fu_rd;
    logic [255:0] fu_data;
    logic [1:0] wbv, stl;
    logic [1:0][3:0] rdy;
    logic [1:0][4:0] wbrd;
    logic [1:0][63:0] wbd;
    logic [1:0][1:0] wbfu;
    int checks = 0, failures = 0, cyc = 0;
    exe_wb_result_t mq [2][4][$];
    int mrr [2];
    always #5 clk = ~clk;
    exe_wb_arbiter #(.RR_MODE(1), .DROP_X0(1)) u_rr (
        .clk_i(clk), .rst_i(rst), .kill_i(kill), .fu_valid_i(fu_valid), .fu_rd_i(fu_rd),
        .fu_data_i(fu_data), .fu_ready_o(rdy[0]), .wb_valid_o(wbv[0]), .wb_rd_o(wbrd[0]),
        .wb_data_o(wbd[0]), .wb_fu_o(wbfu[0]), .wb_ready_i(wb_ready), .stall_o(stl[0]));
    exe_wb_arbiter #(.RR_MODE(0), .DROP_X0(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .kill_i(kill), .fu_valid_i(fu_valid), .fu_rd_i(fu_rd),
        .fu_data_i(fu_data), .fu_ready_o(rdy[1]), .wb_valid_o(wbv[1]), .wb_rd_o(wbrd[1]),
        .wb_data_o(wbd[1]), .wb_fu_o(wbfu[1]), .wb_ready_i(wb_ready), .stall_o(stl[1]));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask
    task automatic set_ch(input int k, input bit v, input logic [4:0] rd, input logic [63:0] d);
        fu_valid[k] = v;
        fu_rd[k*5 +: 5] = rd;
        fu_data[k*64 +: 64] = d;
    endtask
    task automatic tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit any = 0, ev;
            int g = 0, base;
            bit [3:0] r, acc;
            exe_wb_result_t h = '0;
            base = (m == 0) ? mrr[m] : 0;
            for (int i = 0; i < 4; i++) begin
                int c = (base + i) % 4;
                if (!any && mq[m][c].size() > 0) begin any = 1; g = c; end
            end
            ev = any && !kill;
            if (ev) h = mq[m][g][0];
            for (int k = 0; k < 4; k++) r[k] = mq[m][k].size() != 2;
            chk($sformatf("m%0d wb_valid", m), 64'(wbv[m]), 64'(ev));
            chk($sformatf("m%0d wb_rd", m), 64'(wbrd[m]), 64'(h.rd));
            chk($sformatf("m%0d wb_data", m), wbd[m], h.data);
            chk($sformatf("m%0d wb_fu", m), 64'(wbfu[m]), 64'(h.fu));
            chk($sformatf("m%0d fu_ready", m), 64'(rdy[m]), 64'(r));
            chk($sformatf("m%0d stall", m), 64'(stl[m]), 64'(r != 4'hF));
            if (rst) begin
                for (int k = 0; k < 4; k++) mq[m][k].delete();
                mrr[m] = 0;
            end else if (kill) begin
                for (int k = 0; k < 4; k++) mq[m][k].delete();
            end else begin
                for (int k = 0; k < 4; k++)
                    acc[k] = fu_valid[k] && r[k] && !(m == 0 && fu_rd[k*5 +: 5] == 5'd0);
                if (ev && wb_ready) begin
                    void'(mq[m][g].pop_front());
                    if (m == 0) mrr[m] = (g + 1) % 4;
                end
                for (int k = 0; k < 4; k++)
                    if (acc[k]) mq[m][k].push_back('{rd: fu_rd[k*5 +: 5], data: fu_data[k*64 +: 64], fu: 2'(k)});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic idle(input int n);
        fu_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        rst = 1; kill = 0; wb_ready = 0; fu_valid = 4'hF; fu_rd = '0; fu_data = '0;
        mrr[0] = 0; mrr[1] = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) set_ch(k, 1, 5'(k + 1), 64'hF0 + 64'(k));
        tick();
        rst = 0;
        idle(1);
        for (int k = 0; k < 4; k++) set_ch(k, 1, 5'(k + 1), 64'hA0 + 64'(k));
        wb_ready = 1;
        tick();
        idle(6);
        wb_ready = 0;
        for (int i = 0; i < 3; i++) begin set_ch(2, 1, 5'd7, 64'hB0 + 64'(i)); tick(); end
        idle(2);
        wb_ready = 1;
        idle(4);
        for (int i = 0; i < 10; i++) begin
            set_ch(0, 1, 5'd9, 64'hC0 + 64'(i));
            set_ch(3, 1, 5'd10, 64'hD0 + 64'(i));
            tick();
        end
        fu_valid[0] = 0;
        for (int i = 0; i < 4; i++) begin set_ch(3, 1, 5'd11, 64'hE0 + 64'(i)); tick(); end
        idle(4);
        wb_ready = 0;
        for (int k = 0; k < 4; k++) set_ch(k, 1, 5'(k + 12), 64'h100 + 64'(k));
        tick();
        fu_valid = '0;
        set_ch(0, 1, 5'd20, 64'h104);
        tick();
        fu_valid = '0;
        set_ch(1, 1, 5'd21, 64'hBEEF);
        kill = 1;
        tick();
        kill = 0;
        wb_ready = 1;
        idle(4);
        set_ch(1, 1, 5'd0, 64'hDEAD);
        tick();
        idle(3);
        wb_ready = 0;
        for (int i = 0; i < 2; i++) begin set_ch(0, 1, 5'd3, 64'h200 + 64'(i)); tick(); end
        wb_ready = 1;
        set_ch(0, 1, 5'd3, 64'h202);
        tick();
        set_ch(0, 1, 5'd3, 64'h203);
        tick();
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                set_ch(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), {$urandom, $urandom});
            wb_ready = $urandom_range(0, 9) < 7;
            kill = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 0; kill = 0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
